// File: rtl/trap_pkg.sv
// Shared types and cause codes for the machine-mode trap sequencer.
// Optional feature macro used by the block: TRAP_VECTORED_EN.
package trap_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        COMMIT,
        REDIRECT
    } trap_state_e;

    typedef enum logic [1:0] {
        TK_EXC,
        TK_IRQ,
        TK_RET
    } trap_kind_e;

    localparam logic [4:0] CAUSE_MSI = 5'd3;
    localparam logic [4:0] CAUSE_MTI = 5'd7;
    localparam logic [4:0] CAUSE_MEI = 5'd11;

    localparam int IRQ_MSI_BIT = 3;
    localparam int IRQ_MTI_BIT = 7;
    localparam int IRQ_MEI_BIT = 11;

endpackage

// File: rtl/trap_sequencer_irq_arbiter.sv
// Combinational priority pick among enabled machine interrupts.
// Priority MEI > MSI > MTI, all gated by mstatus.MIE.
module irq_arbiter
    import trap_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_mie_global,
    input  logic [XLEN-1:0] i_mie,
    input  logic [XLEN-1:0] i_mip,
    output logic            o_irq_valid,
    output logic [4:0]      o_irq_code
);

    logic w_mei;
    logic w_msi;
    logic w_mti;
    logic w_unused;

    assign w_mei = i_mie_global & i_mie[IRQ_MEI_BIT] & i_mip[IRQ_MEI_BIT];
    assign w_msi = i_mie_global & i_mie[IRQ_MSI_BIT] & i_mip[IRQ_MSI_BIT];
    assign w_mti = i_mie_global & i_mie[IRQ_MTI_BIT] & i_mip[IRQ_MTI_BIT];
    assign w_unused = ^{i_mie, i_mip};

    always_comb begin
        o_irq_valid = 1'b0;
        o_irq_code  = 5'd0;
        priority case (1'b1)
            w_mei: begin
                o_irq_valid = 1'b1;
                o_irq_code  = CAUSE_MEI;
            end
            w_msi: begin
                o_irq_valid = 1'b1;
                o_irq_code  = CAUSE_MSI;
            end
            w_mti: begin
                o_irq_valid = 1'b1;
                o_irq_code  = CAUSE_MTI;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/trap_sequencer.sv
// Trap sequencer: arbitrate, flush, strobe the CSR file, then redirect fetch.
// Define TRAP_VECTORED_EN to honour mtvec MODE=1 for interrupts.
module trap_sequencer
    import trap_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            MIE,
    input  logic [XLEN-1:0] mie,
    input  logic [XLEN-1:0] mip,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    input  logic            exc_valid,
    input  logic [4:0]      exc_code,
    input  logic [XLEN-1:0] exc_pc,
    input  logic            mret_valid,
    input  logic [XLEN-1:0] next_pc,
    input  logic            pipe_idle,
    input  logic            redirect_ready,
    output logic            flush_req,
    output logic            int_action,
    output logic            exp_action,
    output logic            ret_action,
    output logic            hw_int,
    output logic [4:0]      int_code,
    output logic [XLEN-1:0] current_pc,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam int CW = $clog2(FLUSH_CYCLES) + 1;
    localparam logic [CW-1:0] FLUSH_LAST = CW'(FLUSH_CYCLES - 1);

    trap_state_e     r_state;
    trap_kind_e      r_kind;
    logic [4:0]      r_code;
    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   r_cnt;
    logic            r_flush;
    logic            r_int;
    logic            r_exp;
    logic            r_ret;
    logic            r_hw;
    logic [4:0]      r_int_code;
    logic [XLEN-1:0] r_cur_pc;
    logic            r_rvalid;
    logic [XLEN-1:0] r_rpc;

    logic            w_irq_valid;
    logic [4:0]      w_irq_code;
    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_target;
    logic            w_vec;
    logic            w_unused;

    irq_arbiter #(.XLEN(XLEN)) u_arb (
        .i_mie_global (MIE),
        .i_mie        (mie),
        .i_mip        (mip),
        .o_irq_valid  (w_irq_valid),
        .o_irq_code   (w_irq_code)
    );

    assign w_base   = {mtvec[XLEN-1:2], 2'b00};
    assign w_unused = ^mtvec[1:0];

`ifdef TRAP_VECTORED_EN
    assign w_vec = (mtvec[1:0] == 2'b01) && (r_kind == TK_IRQ);
`else
    assign w_vec = 1'b0;
`endif

    // Target is sampled from the CSRs during COMMIT and then frozen.
    assign w_target = (r_kind == TK_RET) ? mepc :
                      w_vec ? w_base + XLEN'({r_code, 2'b00}) :
                      w_base;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_kind     <= TK_EXC;
            r_code     <= '0;
            r_pc       <= '0;
            r_cnt      <= '0;
            r_flush    <= 1'b0;
            r_int      <= 1'b0;
            r_exp      <= 1'b0;
            r_ret      <= 1'b0;
            r_hw       <= 1'b0;
            r_int_code <= '0;
            r_cur_pc   <= '0;
            r_rvalid   <= 1'b0;
            r_rpc      <= '0;
        end else begin
            r_int      <= 1'b0;
            r_exp      <= 1'b0;
            r_ret      <= 1'b0;
            r_hw       <= 1'b0;
            r_int_code <= '0;
            r_cur_pc   <= '0;
            unique case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (exc_valid) begin
                        r_kind  <= TK_EXC;
                        r_code  <= exc_code;
                        r_pc    <= exc_pc;
                        r_flush <= 1'b1;
                        r_state <= FLUSH;
                    end else if (w_irq_valid) begin
                        r_kind  <= TK_IRQ;
                        r_code  <= w_irq_code;
                        r_pc    <= next_pc;
                        r_flush <= 1'b1;
                        r_state <= FLUSH;
                    end else if (mret_valid) begin
                        r_kind  <= TK_RET;
                        r_code  <= '0;
                        r_pc    <= exc_pc;
                        r_flush <= 1'b1;
                        r_state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (r_cnt >= FLUSH_LAST && pipe_idle) begin
                        r_int      <= (r_kind == TK_IRQ);
                        r_exp      <= (r_kind == TK_EXC);
                        r_ret      <= (r_kind == TK_RET);
                        r_hw       <= (r_kind == TK_IRQ);
                        r_int_code <= r_code;
                        r_cur_pc   <= r_pc;
                        r_state    <= COMMIT;
                    end else if (r_cnt < FLUSH_LAST) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                COMMIT: begin
                    r_rpc    <= w_target;
                    r_rvalid <= 1'b1;
                    r_state  <= REDIRECT;
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        r_rvalid <= 1'b0;
                        r_flush  <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign flush_req      = r_flush;
    assign int_action     = r_int;
    assign exp_action     = r_exp;
    assign ret_action     = r_ret;
    assign hw_int         = r_hw;
    assign int_code       = r_int_code;
    assign current_pc     = r_cur_pc;
    assign redirect_valid = r_rvalid;
    assign redirect_pc    = r_rpc;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: vector table, corner sequences, random traffic.
// Honours TRAP_VECTORED_EN for expected redirect targets.
module tb_trap_sequencer;

    localparam int K_NONE = 0;
    localparam int K_EXC  = 1;
    localparam int K_IRQ  = 2;
    localparam int K_RET  = 3;

    typedef struct {
        logic        exc;
        logic [4:0]  code;
        logic [31:0] epc;
        logic        mstat;
        logic [31:0] ie;
        logic [31:0] ip;
        logic        mret;
        logic [31:0] mepc_v;
        logic [31:0] mtvec_v;
        logic [31:0] npc;
    } vec_t;

    typedef struct {
        vec_t        v;
        int          kind;
        logic [4:0]  code;
        logic [31:0] pc;
        logic [31:0] rpc;
    } row_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        MIE;
    logic [31:0] mie, mip, mtvec, mepc;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        mret_valid;
    logic [31:0] next_pc;
    logic        pipe_idle;
    logic        redirect_ready;
    logic        flush_req, int_action, exp_action, ret_action, hw_int;
    logic [4:0]  int_code;
    logic [31:0] current_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;
    row_t tbl[8];

    always #5 clk = ~clk;

    trap_sequencer #(.XLEN(32), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .reset_n(reset_n), .MIE(MIE), .mie(mie), .mip(mip),
        .mtvec(mtvec), .mepc(mepc), .exc_valid(exc_valid),
        .exc_code(exc_code), .exc_pc(exc_pc), .mret_valid(mret_valid),
        .next_pc(next_pc), .pipe_idle(pipe_idle),
        .redirect_ready(redirect_ready), .flush_req(flush_req),
        .int_action(int_action), .exp_action(exp_action),
        .ret_action(ret_action), .hw_int(hw_int), .int_code(int_code),
        .current_pc(current_pc), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic exc, input logic [4:0] code,
                                 input logic [31:0] epc, input logic ms,
                                 input logic [31:0] ie, input logic [31:0] ip,
                                 input logic mret, input logic [31:0] mp,
                                 input logic [31:0] tv, input logic [31:0] npc);
        vec_t v;
        v.exc = exc; v.code = code; v.epc = epc; v.mstat = ms;
        v.ie = ie; v.ip = ip; v.mret = mret; v.mepc_v = mp;
        v.mtvec_v = tv; v.npc = npc;
        return v;
    endfunction

    function automatic row_t mkr(input vec_t v, input int k,
                                 input logic [4:0] c, input logic [31:0] pc,
                                 input logic [31:0] rpc);
        row_t r;
        r.v = v; r.kind = k; r.code = c; r.pc = pc; r.rpc = rpc;
        return r;
    endfunction

    // Reference: decide the trap from architectural rules, then its target.
    function automatic row_t model(input vec_t v);
        row_t r;
        int bits[3] = '{11, 3, 7};
        logic [31:0] base;
        r.v = v; r.kind = K_NONE; r.code = 0; r.pc = 0; r.rpc = 0;
        base = v.mtvec_v & ~32'h3;
        if (v.exc) begin
            r.kind = K_EXC; r.code = v.code; r.pc = v.epc; r.rpc = base;
        end else begin
            for (int i = 0; i < 3; i++)
                if (r.kind == K_NONE && v.mstat && v.ie[bits[i]] && v.ip[bits[i]]) begin
                    r.kind = K_IRQ; r.code = 5'(bits[i]);
                    r.pc = v.npc; r.rpc = base;
                end
`ifdef TRAP_VECTORED_EN
            if (r.kind == K_IRQ && v.mtvec_v[1:0] == 2'b01)
                r.rpc = base + 32'(r.code) * 4;
`endif
            if (r.kind == K_NONE && v.mret) begin
                r.kind = K_RET; r.code = 0; r.rpc = v.mepc_v;
            end
        end
        return r;
    endfunction

    task automatic quiet();
        exc_valid = 0; mret_valid = 0; MIE = 0; mie = 0; mip = 0;
    endtask

    task automatic apply(input vec_t v);
        exc_valid = v.exc; exc_code = v.code; exc_pc = v.epc;
        MIE = v.mstat; mie = v.ie; mip = v.ip; mret_valid = v.mret;
        mepc = v.mepc_v; mtvec = v.mtvec_v; next_pc = v.npc;
    endtask

    task automatic run_txn(input row_t e, input int idle_d, input int rdy_d);
        int strobes = 0, accepted = 0, rcnt = 0, s_kind = K_NONE;
        bit done = 0, seen_rv = 0, drop = 0, unstable = 0;
        logic [31:0] rpc0 = 0, s_pc = 0;
        logic [4:0] s_code = 0;
        logic s_hw = 0;
        @(negedge clk);
        chk("idle_flush", flush_req, 0);
        apply(e.v);
        pipe_idle = (idle_d == 0);
        redirect_ready = 0;
        if (e.kind == K_NONE) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (flush_req | int_action | exp_action | ret_action) drop = 1;
            end
            chk("none_quiet", drop, 0);
            quiet();
            return;
        end
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (c == 0) begin
                exc_valid = 0; mret_valid = 0;
                MIE = 1'($urandom); mip = $urandom;
                exc_code = 5'($urandom); exc_pc = $urandom; next_pc = $urandom;
            end
            pipe_idle = (c + 1 >= idle_d);
            if (!flush_req) drop = 1;
            if (int_action | exp_action | ret_action) begin
                strobes += $countones({int_action, exp_action, ret_action});
                s_kind = int_action ? K_IRQ : exp_action ? K_EXC : K_RET;
                s_code = int_code; s_pc = current_pc; s_hw = hw_int;
            end
            if (redirect_valid) begin
                if (!seen_rv) begin
                    seen_rv = 1; rpc0 = redirect_pc;
                end else if (redirect_pc !== rpc0) begin
                    unstable = 1;
                end
                if (rcnt >= rdy_d) begin
                    redirect_ready = 1; accepted++; done = 1;
                    MIE = 0; mip = 0;
                end else begin
                    rcnt++;
                end
            end
        end
        @(negedge clk);
        redirect_ready = 0;
        pipe_idle = 1;
        chk("flush_release", flush_req, 0);
        chk("rvalid_release", redirect_valid, 0);
        chk("flush_held", drop, 0);
        chk("strobe_count", strobes, 1);
        chk("accepted", accepted, 1);
        chk("kind", s_kind, e.kind);
        chk("int_code", s_code, e.code);
        chk("hw_int", s_hw, (e.kind == K_IRQ));
        if (e.kind != K_RET) chk("current_pc", s_pc, e.pc);
        chk("redirect_pc", rpc0, e.rpc);
        chk("rpc_stable", unstable, 0);
    endtask

    function automatic logic [31:0] irq_rand();
        logic [31:0] x;
        x = $urandom & 32'hFFFF_F777;
        if ($urandom_range(0, 1) == 1) x[11] = 1;
        if ($urandom_range(0, 1) == 1) x[3] = 1;
        if ($urandom_range(0, 1) == 1) x[7] = 1;
        return x;
    endfunction

    initial begin
        vec_t v;
        bit bad;
        reset_n = 0; quiet();
        exc_code = 0; exc_pc = 0; mepc = 0; mtvec = 0; next_pc = 0;
        pipe_idle = 1; redirect_ready = 0;
        #1;
        chk("reset_outputs",
            {flush_req, int_action, exp_action, ret_action, hw_int,
             int_code, current_pc, redirect_valid, redirect_pc}, 0);
        @(negedge clk); @(negedge clk);
        reset_n = 1;

        tbl[0] = mkr(mkv(1, 2, 32'h100, 0, 0, 0, 0, 0, 32'h800, 0),
                     K_EXC, 2, 32'h100, 32'h800);
`ifdef TRAP_VECTORED_EN
        tbl[1] = mkr(mkv(0, 0, 0, 1, 32'h888, 32'h888, 0, 0, 32'h801, 32'h2000),
                     K_IRQ, 11, 32'h2000, 32'h82C);
        tbl[4] = mkr(mkv(0, 0, 0, 1, 32'h80, 32'h88, 0, 0, 32'h801, 32'h3000),
                     K_IRQ, 7, 32'h3000, 32'h81C);
        tbl[6] = mkr(mkv(0, 0, 0, 1, 32'h88, 32'h88, 0, 0, 32'hFFFF_FFFD, 32'h40),
                     K_IRQ, 3, 32'h40, 32'h8);
`else
        tbl[1] = mkr(mkv(0, 0, 0, 1, 32'h888, 32'h888, 0, 0, 32'h801, 32'h2000),
                     K_IRQ, 11, 32'h2000, 32'h800);
        tbl[4] = mkr(mkv(0, 0, 0, 1, 32'h80, 32'h88, 0, 0, 32'h801, 32'h3000),
                     K_IRQ, 7, 32'h3000, 32'h800);
        tbl[6] = mkr(mkv(0, 0, 0, 1, 32'h88, 32'h88, 0, 0, 32'hFFFF_FFFD, 32'h40),
                     K_IRQ, 3, 32'h40, 32'hFFFF_FFFC);
`endif
        tbl[2] = mkr(mkv(0, 0, 0, 0, 0, 0, 1, 32'h1234, 32'h800, 0),
                     K_RET, 0, 0, 32'h1234);
        tbl[3] = mkr(mkv(1, 5, 32'h44, 1, 32'h80, 32'h80, 0, 0, 32'h801, 32'h50),
                     K_EXC, 5, 32'h44, 32'h800);
        tbl[5] = mkr(mkv(0, 0, 0, 0, 32'h888, 32'h888, 1, 32'h40, 32'h800, 0),
                     K_RET, 0, 0, 32'h40);
        tbl[7] = mkr(mkv(1, 31, 32'hFFFF_FFFC, 0, 0, 0, 1, 32'h99, 32'h1234_5679, 0),
                     K_EXC, 31, 32'hFFFF_FFFC, 32'h1234_5678);

        for (int i = 0; i < 8; i++) run_txn(tbl[i], 0, 0);

        // Exception and interrupt together: exception first, irq on a later pass.
        run_txn(tbl[3], 0, 0);
        v = tbl[3].v; v.exc = 0;
        run_txn(model(v), 0, 0);

        // Slow drain and stalled fetch.
        run_txn(tbl[0], 5, 3);
        run_txn(tbl[1], 3, 2);

        // Reset in the middle of FLUSH.
        @(negedge clk);
        apply(tbl[0].v); pipe_idle = 0;
        @(negedge clk);
        exc_valid = 0;
        @(negedge clk);
        chk("flush_before_reset", flush_req, 1);
        #2 reset_n = 0;
        #1;
        chk("reset_mid_outputs",
            {flush_req, int_action, exp_action, ret_action, hw_int,
             int_code, current_pc, redirect_valid, redirect_pc}, 0);
        @(negedge clk);
        reset_n = 1; pipe_idle = 1; quiet();
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (flush_req | int_action | exp_action | ret_action | redirect_valid)
                bad = 1;
        end
        chk("no_strobe_after_reset", bad, 0);

        for (int n = 0; n < 40; n++) begin
            v.exc = ($urandom_range(0, 3) == 0);
            v.code = 5'($urandom);
            v.epc = $urandom & ~32'h3;
            v.mstat = 1'($urandom_range(0, 1));
            v.ie = irq_rand();
            v.ip = irq_rand();
            v.mret = ($urandom_range(0, 2) == 0);
            v.mepc_v = $urandom;
            v.mtvec_v = ($urandom & ~32'h3) | 32'($urandom_range(0, 1));
            v.npc = $urandom & ~32'h3;
            if ($urandom_range(0, 5) == 0) begin
                v.exc = 0; v.mret = 0;
            end
            run_txn(model(v), $urandom_range(0, 4), $urandom_range(0, 4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
